srdl2sv_reg_if_slice: RTL



---
 rtl/srdl2sv_reg_if_slice_if.sv | 24 ++
 rtl/srdl2sv_reg_if_slice.sv | 116 +++++++++++
 2 files changed

// File: rtl/srdl2sv_reg_if_slice_if.sv
// Register-access bus (b2r request + r2b response) between a bus widget and register logic.
// master drives the request and receives the response; slave does the opposite.
interface srdl2sv_reg_if_slice_if #(
  parameter int BUS_BITS = 32
);
  logic [31:0]           addr;
  logic [BUS_BITS-1:0]   wdata;
  logic [BUS_BITS/8-1:0] byte_en;
  logic                  w_vld;
  logic                  r_vld;
  logic [BUS_BITS-1:0]   rdata;
  logic                  rdy;
  logic                  err;

  modport master (
    output addr, wdata, byte_en, w_vld, r_vld,
    input  rdata, rdy, err
  );

  modport slave (
    input  addr, wdata, byte_en, w_vld, r_vld,
    output rdata, rdy, err
  );
endinterface

// File: rtl/srdl2sv_reg_if_slice.sv
// Registered request/response slice on the register interface, one access in flight.
// Define SRDL2SV_REG_IF_TIMEOUT_EN to abort accesses the register logic never acknowledges.
//
// state | meaning
// IDLE  | waiting for an upstream request
// REQ   | request presented downstream, waiting for rdy (or abort)
// RESP  | one-cycle response to the bus widget
module srdl2sv_reg_if_slice #(
  parameter int BUS_BITS       = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  srdl2sv_reg_if_slice_if.slave          s_bus,
  srdl2sv_reg_if_slice_if.master         m_bus,
  output logic                           timeout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic       single_vld;
  logic       both_vld;

  assign single_vld = s_bus.w_vld ^ s_bus.r_vld;
  assign both_vld   = s_bus.w_vld & s_bus.r_vld;

`ifdef SRDL2SV_REG_IF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             expired;

  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES));

  // Counts REQ cycles, 1 in the first; parks at the limit so it cannot wrap.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE:    cnt <= single_vld ? CNT_W'(1) : '0;
        REQ:     if (!m_bus.rdy && !expired) cnt <= cnt + CNT_W'(1);
        default: cnt <= '0;
      endcase
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state         <= IDLE;
      m_bus.addr    <= '0;
      m_bus.wdata   <= '0;
      m_bus.byte_en <= '0;
      m_bus.w_vld   <= 1'b0;
      m_bus.r_vld   <= 1'b0;
      s_bus.rdata   <= '0;
      s_bus.rdy     <= 1'b0;
      s_bus.err     <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (single_vld) begin
            m_bus.addr    <= s_bus.addr;
            m_bus.wdata   <= s_bus.wdata;
            m_bus.byte_en <= s_bus.byte_en;
            m_bus.w_vld   <= s_bus.w_vld;
            m_bus.r_vld   <= s_bus.r_vld;
            state         <= REQ;
          end else if (both_vld) begin
            // Ambiguous op: reject without touching the register logic.
            s_bus.rdata <= '0;
            s_bus.err   <= 1'b1;
            s_bus.rdy   <= 1'b1;
            state       <= RESP;
          end
        end
        REQ: begin
          if (m_bus.rdy) begin
            m_bus.w_vld <= 1'b0;
            m_bus.r_vld <= 1'b0;
            s_bus.rdata <= m_bus.r_vld ? m_bus.rdata : '0;
            s_bus.err   <= m_bus.err;
            s_bus.rdy   <= 1'b1;
            state       <= RESP;
          end
`ifdef SRDL2SV_REG_IF_TIMEOUT_EN
          else if (expired) begin
            m_bus.w_vld <= 1'b0;
            m_bus.r_vld <= 1'b0;
            s_bus.rdata <= '0;
            s_bus.err   <= 1'b1;
            s_bus.rdy   <= 1'b1;
            timeout     <= 1'b1;
            state       <= RESP;
          end
`endif
        end
        RESP: begin
          s_bus.rdy <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
